// File: rtl/count_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : count_display_pkg
//  Description : Shared types and constants for the count_display stage:
//                conversion FSM states, seven-segment patterns, digit indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package count_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Segment patterns, bit0 = a ... bit6 = g, active high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_ERR   = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] DIG_UNITS    = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_encode = SEG_0;
            4'd1:    seg_encode = SEG_1;
            4'd2:    seg_encode = SEG_2;
            4'd3:    seg_encode = SEG_3;
            4'd4:    seg_encode = SEG_4;
            4'd5:    seg_encode = SEG_5;
            4'd6:    seg_encode = SEG_6;
            4'd7:    seg_encode = SEG_7;
            4'd8:    seg_encode = SEG_8;
            4'd9:    seg_encode = SEG_9;
            default: seg_encode = SEG_ERR;
        endcase
    endfunction

    // Double-dabble nibble correction applied before each shift
    function automatic logic [3:0] add3(input logic [3:0] nib);
        add3 = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage
`default_nettype wire

// File: rtl/count_display_bin2bcd.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential 8-bit binary to 3-digit BCD converter using the
//                shift-and-add-3 method, one bit per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import count_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        busy
);

    state_t       r_state;
    logic [19:0]  r_shift;
    logic [2:0]   r_cnt;
    logic [11:0]  r_bcd;
    logic         r_busy;
    logic [19:0]  w_adj;

    assign w_adj = {add3(r_shift[19:16]), add3(r_shift[15:12]),
                    add3(r_shift[11:8]), r_shift[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift <= {12'h000, bin};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_shift <= {w_adj[18:0], 1'b0};
                    r_cnt   <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_bcd   <= r_shift[19:8];
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bcd  = r_bcd;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/count_display.sv
`default_nettype none
// ============================================================================
//  Module      : count_display
//  Description : Converts the counter value to BCD and scans it onto a
//                three-digit multiplexed seven-segment display.
//                Option macro COUNT_DISPLAY_BLANK_EN blanks leading zeros.
//  Revision    : 1.0 - initial release
// ============================================================================
module count_display
    import count_display_pkg::*;
#(
    parameter int SCAN_DIV = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cmpt,
    output logic [6:0]  seg,
    output logic [2:0]  dig,
    output logic        busy,
    output logic [11:0] bcd
);

    localparam int                 c_pre_w    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(SCAN_DIV - 1);

    logic [7:0]         r_last_val;
    logic               w_start;
    logic [c_pre_w-1:0] r_pre;
    logic [1:0]         r_idx;
    logic [6:0]         r_seg;
    logic [2:0]         r_dig;
    logic               w_tc;
    logic [1:0]         w_idx_next;
    logic [3:0]         w_nib;
    logic [2:0]         w_onehot;
    logic               w_blank;

    // The value is remembered at the start edge; cmpt is ignored while busy,
    // so this matches remembering it on completion.
    assign w_start = !busy && (cmpt != r_last_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_val <= '0;
        end else if (w_start) begin
            r_last_val <= cmpt;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .bin   (cmpt),
        .bcd   (bcd),
        .busy  (busy)
    );

    assign w_tc = (r_pre == c_pre_last);

    always_comb begin
        w_idx_next = r_idx;
        if (w_tc) begin
            w_idx_next = (r_idx == DIG_HUNDREDS) ? DIG_UNITS : (r_idx + 2'd1);
        end
    end

    // Pattern is chosen for the index being loaded so seg and dig stay paired
    always_comb begin
        w_nib    = bcd[3:0];
        w_onehot = 3'b001;
        w_blank  = 1'b0;
        case (w_idx_next)
            DIG_TENS: begin
                w_nib    = bcd[7:4];
                w_onehot = 3'b010;
            end
            DIG_HUNDREDS: begin
                w_nib    = bcd[11:8];
                w_onehot = 3'b100;
            end
            default: begin
                w_nib    = bcd[3:0];
                w_onehot = 3'b001;
            end
        endcase
`ifdef COUNT_DISPLAY_BLANK_EN
        w_blank = ((w_idx_next == DIG_HUNDREDS) && (bcd[11:8] == 4'd0)) ||
                  ((w_idx_next == DIG_TENS) && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0));
`else
        w_blank = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= DIG_UNITS;
            r_dig <= 3'b001;
            r_seg <= SEG_0;
        end else begin
            r_pre <= w_tc ? '0 : (r_pre + c_pre_w'(1));
            r_idx <= w_idx_next;
            r_dig <= w_onehot;
            r_seg <= w_blank ? SEG_BLANK : seg_encode(w_nib);
        end
    end

    assign seg = r_seg;
    assign dig = r_dig;

endmodule
`default_nettype wire

// File: doc/count_display.md
# count_display

Display stage directly downstream of the 8-bit `counter`. It samples the counter value `cmpt` and converts it to three BCD digits with a sequential double-dabble engine. It then drives a time-multiplexed, three-digit seven-segment display. It gives the design a human-readable view of the count on the Tiny Tapeout output pins.

## Interface
- `SCAN_DIV`, default 1024: clock cycles each digit stays enabled. Legal values ≥1. Prescaler width is `$clog2(SCAN_DIV)`, minimum 1.
- `clk`  in  1  : single clock, rising edge.
- `rst`  in  1  : reset, synchronous, active-high.
- `cmpt`  in  8  : count value from `counter`, unsigned 0–255.
- `seg`  out  7  : segment drive, active high. bit0=a … bit6=g.
- `dig`  out  3  : one-hot digit enable. bit0=units, bit1=tens, bit2=hundreds.
- `busy`  out  1  : conversion in progress.
- `bcd`  out  12  : last completed conversion as {hundreds, tens, units}, one nibble each.

## Operation
- Conversion FSM states: IDLE, SHIFT, DONE.
  - IDLE:
    - If `cmpt != last_val`, load the shift register with {12'h000, `cmpt`}, set iteration count to 0 and go to SHIFT.
    - Otherwise stay in IDLE.
    - `cmpt` is sampled only in IDLE and ignored while `busy`.
  - SHIFT: each cycle, add 3 to every BCD nibble that is ≥5, then shift the 20-bit register left by 1. After the 8th shift, go to DONE.
  - DONE: `bcd` ← upper 12 bits of the register, `last_val` ← the captured value, go to IDLE.
- `busy` = 1 in SHIFT and DONE.
- Scan path:
  - Prescaler counts 0..`SCAN_DIV`-1.
  - At the terminal count it wraps to 0 and the digit index advances 0→1→2→0.
  - `dig` = one-hot of the digit index.
- Segment encoding, nibble → `seg`: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. Nibbles >9 give 40 (g only, defensive).
- `seg` and `dig` are registered together, so they never show mismatched digit/pattern pairs.
- With a free-running counter, a new conversion starts every 10 cycles. Each result is exact for the value sampled at its start.

## Timing
- Reset values:
  - FSM IDLE, `last_val`=0, `bcd`=12'h000, `busy`=0.
  - Prescaler 0, digit index 0, `dig`=3'b001, `seg`=7'h3F.
- Latency:
  - Sampling edge E0 loads the register and `busy` rises after E0.
  - E1–E8 perform the shifts.
  - E9 updates `bcd`, `busy` falls and the FSM returns to IDLE.
  - The earliest next sample is E10.
- `seg`/`dig` reflect a new `bcd` value at the next edge after E9.
- Boundaries:
  - `cmpt` 255→0 wrap is treated as an ordinary change, giving `bcd`=000.
  - `cmpt` equal to `last_val` causes no conversion.
  - `rst` at any point, including mid-SHIFT, aborts the conversion and restores all reset values on that edge. The partial result is discarded.
  - `SCAN_DIV`=1 advances the digit every cycle.

## Configuration
- `COUNT_DISPLAY_BLANK_EN` defined: leading zeros are blanked (`seg`=0).
  - Hundreds is blanked when its digit is 0.
  - Tens is blanked when hundreds and tens are both 0.
  - Units is never blanked.
- Undefined: all three digits are always shown, and zeros display as 3F.
- Blanking affects only `seg`. `bcd` and `dig` are identical in both builds.

## Structure
- Shared package `count_display_pkg` holds:
  - FSM state enum.
  - Segment constants `SEG_0`…`SEG_9` and `SEG_ERR`.
  - Digit index constants.
- Sub-module `bin2bcd_seq` contains the IDLE/SHIFT/DONE engine.
  - Ports: `clk`, `rst`, `start`, `bin[7:0]`, `bcd[11:0]`, `busy`.
- The top level holds change detection, the scan prescaler and segment encoding.

## Test plan
- Reset: `rst`=1 for 2 cycles with `cmpt`=0 → `bcd`=000, `busy`=0, `dig`=001, `seg`=3F, with no conversion after release.
- Max value: hold `cmpt`=255 → `busy` high for 9 cycles, then `bcd`=12'h255. Scanning gives units 6D, tens 6D, hundreds 5B.
- Blanking: `cmpt`=7.
  - With `COUNT_DISPLAY_BLANK_EN`: hundreds `seg`=00, tens `seg`=00, units `seg`=07.
  - Without it: 3F, 3F, 07.
- Scan: `SCAN_DIV`=4 → `dig` sequence 001→010→100→001, each held exactly 4 cycles.
- Free-running `counter` upstream → a conversion every 10 cycles. Each `bcd` matches the BCD of `cmpt` at its start edge, including across the 255→0 wrap.
- Reset mid-conversion: assert `rst` 3 cycles into SHIFT → next edge `busy`=0, `bcd`=000. Release with `cmpt`=100 → `bcd`=12'h100 after 10 edges.
